// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port 16-bit memory between the fetch (IF) and data (D) requesters.
// One transaction at a time; D has priority, and a starvation counter forces an IF grant.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [15:0]           if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic [15:0]           d_rdata,
  output logic                  d_ack,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out
);

  localparam logic [3:0] WaitInit  = 4'(WAIT_CYCLES);
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_d_q, owner_d_d;  // 1 = data port owns the transaction
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [3:0]            wait_q, wait_d;
  logic [3:0]            starve_q, starve_d;
  logic [15:0]           if_rdata_q, if_rdata_d;
  logic [15:0]           d_rdata_q, d_rdata_d;

  logic                  grant_d;
  logic                  mem_en_c;
  logic                  mem_wr_c;

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d     = 1'b0;
    mem_en_c    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          grant_d   = d_req && !(if_req && (starve_q == StarveMax));
          owner_d_d = grant_d;
          if (grant_d) begin
            addr_d  = {d_addr[ADDR_WIDTH-1:1], 1'b0};
            wr_d    = d_wr;
            wdata_d = d_wr ? d_wdata : 16'h0000;
          end else begin
            addr_d  = {if_addr[ADDR_WIDTH-1:1], 1'b0};
            wr_d    = 1'b0;
            wdata_d = 16'h0000;
          end
          // Count D wins only while IF is actually waiting.
          if (grant_d && if_req) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
          wait_d  = WaitInit;
          state_d = StAccess;
        end
      end

      StAccess: begin
        mem_en_c    = 1'b1;
        mem_addr    = addr_q;
        mem_data_in = wdata_q;
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          mem_wr_c = wr_q;
          if (!wr_q) begin
            if (owner_d_q) d_rdata_d  = mem_data_out;
            else           if_rdata_d = mem_data_out;
          end
          state_d = StResp;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Gated by reset so a write in flight can never commit during a reset cycle.
  assign mem_enable = mem_en_c & ~rst;
  assign mem_wr     = mem_wr_c & ~rst;

  assign if_ack   = (state_q == StResp) & ~owner_d_q & ~rst;
  assign d_ack    = (state_q == StResp) &  owner_d_q & ~rst;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_d_q  <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= 16'h0000;
      wait_q     <= 4'd0;
      starve_q   <= 4'd0;
      if_rdata_q <= 16'h0000;
      d_rdata_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      owner_d_q  <= owner_d_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, 16-bit, byte-addressed memory1c-style array between the instruction-fetch requester (IF) and the data requester (D).
- Serialises accesses, inserts a programmable number of wait states to model slower memory, and enforces "no concurrent read and write" at the array.
- D has priority, and a starvation counter guarantees forward progress for fetch.
- Sits between the fetch/mem stages and the unified memory instance.

Parameters:
- ADDR_WIDTH, 16, byte-address width of requests and memory port.
- WAIT_CYCLES, 2, extra ACCESS cycles per transaction. Legal range is 0..15.
- STARVE_LIMIT, 4, consecutive D grants while IF is waiting before IF is forced to win. Legal range is 1..15.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request. Held with if_addr stable until if_ack.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_rdata  out  16  fetch read data. Registered.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request. Held with d_wr, d_addr and d_wdata stable until d_ack.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  16  write data.
- d_rdata  out  16  data read result. Registered.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address. Bit 0 is forced to 0.
- mem_data_in  out  16  memory write data.
- mem_data_out  in  16  memory combinational read data.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (rst=1 at an edge):
  - state=IDLE, wait_cnt=0, starve_cnt=0.
  - if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, latched owner/addr/wr/wdata=0.
- Reset mid-transaction:
  - The transaction is dropped with no ack.
  - mem_enable and mem_wr are gated by ~rst, so an in-flight write never commits during a reset cycle.
- IDLE, neither request: no change.
- IDLE, any request present: arbitrate.
  - If only one requester is active, it wins.
  - If both are active, D wins unless starve_cnt==STARVE_LIMIT, in which case IF wins.
  - Latch owner, addr with bit 0 cleared, wr (0 when owner is IF), and wdata.
  - Load wait_cnt=WAIT_CYCLES and go to ACCESS.
- starve_cnt update at each arbitration:
  - +1 (saturating at STARVE_LIMIT) when D wins while if_req=1.
  - Cleared when IF wins, or when if_req=0.
- ACCESS:
  - mem_enable=1, mem_addr=latched addr, mem_data_in=latched wdata (0 for reads).
  - If wait_cnt!=0: mem_wr=0 and wait_cnt decrements.
  - If wait_cnt==0 (final cycle):
    - For a write, mem_wr=1, so the write commits on this edge, exactly once.
    - For a read, mem_wr=0, and mem_data_out is captured into the owner's rdata register at this edge.
    - Go to RESP.
- RESP:
  - The owner's ack=1 for exactly this cycle. Memory outputs are idle. Requests are not sampled.
  - Next state is IDLE.
- Outside ACCESS: mem_enable=0, mem_wr=0, mem_addr=0, mem_data_in=0.
- Latency: request visible in IDLE at cycle 0 gives ack high in cycle WAIT_CYCLES+2. One transaction is in flight at a time.
- rdata registers hold their value until the next read completion for the same port. A D write completion leaves d_rdata unchanged.
- Requester rule: after seeing ack, a requester deasserts req or presents a new request. A req still high in the IDLE cycle after ack is treated as a new request.
- Request changes while not granted are legal. Only values present in IDLE at the arbitration edge are latched.

Test Plan:
- Fetch read: WAIT_CYCLES=2, mem[0x0010]=0xBEEF, if_req with if_addr=0x0010 at cycle 0 -> mem_enable high in cycles 1-3, if_ack pulse in cycle 4, if_rdata=0xBEEF, d_ack stays 0.
- Data write then read:
  - d_wr=1, d_addr=0x0021, d_wdata=0x1234 -> mem_addr=0x0020, mem_wr high only in the final ACCESS cycle, one write.
  - Follow-up read of 0x0020 -> d_rdata=0x1234.
  - if_rdata is unchanged throughout.
- Simultaneous requests, STARVE_LIMIT=4: if_req and d_req held continuously, D re-requesting after each ack -> grant order D,D,D,D,IF,D,D,D,D,IF; starve_cnt returns to 0 after each IF grant.
- WAIT_CYCLES=0: d read -> ACCESS lasts 1 cycle, d_ack at cycle 2. Back-to-back fetch reads complete every 3 cycles.
- Reset mid-write: rst=1 during the final ACCESS cycle of a write of 0xAAAA to 0x0040 -> no ack, mem_wr=0 that cycle, memory word unchanged. After rst falls, state is IDLE and all outputs are 0.
- Request changes before grant: d_req held through a pending IF transaction while d_addr changes from 0x0002 to 0x0004 before IDLE -> the access uses 0x0004.
